// File: rtl/riscv_multicycle_controller.sv
// riscv_multicycle_controller
//
// Purpose:
//   Moore-style sequencer for a multi-cycle RV32I datapath. One memory port
//   is shared between instruction fetch and data access. Each instruction
//   walks through FETCH -> DECODE -> class-specific states -> FETCH. An
//   illegal opcode or a memory request that never completes halts the
//   controller in TRAP until reset.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   opcode[6:0]     instruction[6:0] from the IR, meaningful from DECODE on
//   zero            ALU zero flag, used by BRANCH (BEQ only)
//   mem_ready       memory finishes the outstanding request this cycle
//   pc_write        PC load enable
//   ir_write        IR (and oldPC) load enable
//   mem_req/mem_we  memory request and write strobe
//   iord            memory address select: 0=PC, 1=ALUOut
//   alu_src_a[1:0]  0=PC, 1=regA, 2=oldPC
//   alu_src_b[1:0]  0=regB, 1=const 4, 2=immediate
//   alu_op[1:0]     00=add, 01=sub, 10=funct-decoded
//   pc_src          0=ALU result, 1=ALUOut
//   reg_write       register file write enable
//   wb_sel[1:0]     0=ALUOut, 1=MDR, 2=PC
//   instr_retired   one-cycle pulse when an instruction completes
//   retire_count    wrapping retired-instruction counter
//   trap/trap_cause halted; cause 0=illegal opcode, 1=memory timeout
//   state[3:0]      current state, for debug

module riscv_multicycle_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ir_write,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             pc_src,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic             instr_retired,
   output logic [CNT_W-1:0] retire_count,
   output logic             trap,
   output logic             trap_cause,
   output logic [3:0]       state
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_WB_MEM = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC_R = 4'd6;
   localparam logic [3:0] S_EXEC_I = 4'd7;
   localparam logic [3:0] S_WB_ALU = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_JAL    = 4'd10;
   localparam logic [3:0] S_TRAP   = 4'd11;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic [3:0]       state_r, state_n;
   logic [31:0]      wait_cnt;
   logic             cause_r, cause_n;
   logic [CNT_W-1:0] count_r;
   logic             mem_state, waiting, timeout_hit, retire;

   // A memory state is stalled whenever the request is not completed this
   // cycle. The timeout fires on the stalled cycle that brings the wait count
   // up to MEM_TIMEOUT; a ready in that same cycle still wins.
   always_comb begin
      mem_state   = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
      waiting     = mem_state && !mem_ready;
      timeout_hit = (MEM_TIMEOUT > 0) && waiting && ((wait_cnt + 32'd1) >= 32'(MEM_TIMEOUT));
   end

   // Next-state logic. Retirement is flagged explicitly on the transitions
   // that finish an instruction so that recovery from an unused encoding
   // back to FETCH never counts as a retired instruction.
   always_comb begin
      state_n = state_r;
      cause_n = cause_r;
      retire  = 1'b0;
      case (state_r)
         S_FETCH: begin
            if (mem_ready) begin
               state_n = S_DECODE;
            end else if (timeout_hit) begin
               state_n = S_TRAP;
               cause_n = 1'b1;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_n = S_MEMADR;
               OP_R:              state_n = S_EXEC_R;
               OP_I:              state_n = S_EXEC_I;
               OP_BRANCH:         state_n = S_BRANCH;
               OP_JAL:            state_n = S_JAL;
               default: begin
                  state_n = S_TRAP;
                  cause_n = 1'b0;
               end
            endcase
         end
         S_MEMADR: state_n = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
         S_MEMRD: begin
            if (mem_ready) begin
               state_n = S_WB_MEM;
            end else if (timeout_hit) begin
               state_n = S_TRAP;
               cause_n = 1'b1;
            end
         end
         S_MEMWR: begin
            if (mem_ready) begin
               state_n = S_FETCH;
               retire  = 1'b1;
            end else if (timeout_hit) begin
               state_n = S_TRAP;
               cause_n = 1'b1;
            end
         end
         S_EXEC_R, S_EXEC_I: state_n = S_WB_ALU;
         S_WB_MEM, S_WB_ALU, S_BRANCH, S_JAL: begin
            state_n = S_FETCH;
            retire  = 1'b1;
         end
         S_TRAP:  state_n = S_TRAP;
         default: state_n = S_FETCH;
      endcase
   end

   // State, wait counter, trap cause and retire counter. The wait counter
   // restarts whenever the state changes, which covers every entry into a
   // memory state; it only advances while a request is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= S_FETCH;
         wait_cnt <= '0;
         cause_r  <= 1'b0;
         count_r  <= '0;
      end else begin
         state_r <= state_n;
         cause_r <= cause_n;
         if (state_n != state_r) begin
            wait_cnt <= '0;
         end else if (waiting) begin
            wait_cnt <= wait_cnt + 32'd1;
         end
         if (retire) begin
            count_r <= count_r + CNT_W'(1);
         end
      end
   end

   // Output decode from the current state. Everything is forced low while
   // rst is high so a request in flight drops in the reset cycle itself.
   // In TRAP the debug state, cause and retire count stay visible.
   always_comb begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      alu_src_a     = 2'd0;
      alu_src_b     = 2'd0;
      alu_op        = 2'b00;
      pc_src        = 1'b0;
      reg_write     = 1'b0;
      wb_sel        = 2'd0;
      trap          = 1'b0;
      trap_cause    = 1'b0;
      instr_retired = retire;
      retire_count  = count_r;
      state         = state_r;
      case (state_r)
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'd1;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd2;
         end
         S_MEMADR: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_WB_MEM: begin
            reg_write = 1'b1;
            wb_sel    = 2'd1;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 2'd1;
            alu_op    = 2'b10;
         end
         S_EXEC_I: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            alu_op    = 2'b10;
         end
         S_WB_ALU: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = 2'd1;
            alu_op    = 2'b01;
            pc_src    = 1'b1;
            pc_write  = zero;
         end
         S_JAL: begin
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            reg_write = 1'b1;
            wb_sel    = 2'd2;
         end
         S_TRAP: begin
            trap       = 1'b1;
            trap_cause = cause_r;
         end
         default: ;
      endcase
      if (rst) begin
         pc_write      = 1'b0;
         ir_write      = 1'b0;
         mem_req       = 1'b0;
         mem_we        = 1'b0;
         iord          = 1'b0;
         alu_src_a     = 2'd0;
         alu_src_b     = 2'd0;
         alu_op        = 2'b00;
         pc_src        = 1'b0;
         reg_write     = 1'b0;
         wb_sel        = 2'd0;
         trap          = 1'b0;
         trap_cause    = 1'b0;
         instr_retired = 1'b0;
         retire_count  = '0;
         state         = 4'd0;
      end
   end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// tb_riscv_multicycle_controller
//
// Purpose:
//   Scoreboard bench. The stimulus side walks instructions through their
//   phases at instruction level, pushing the expected output vector of each
//   cycle into a queue. A monitor pops one entry every falling edge and
//   compares it with the DUT. MEM_TIMEOUT=4 and CNT_W=4 so timeouts and
//   retire-counter wrap are both reached quickly.
//
// Ports: none (top-level bench).

module tb_riscv_multicycle_controller;

   localparam int TO = 4;
   localparam int CW = 4;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [6:0]    opcode = 7'd0;
   logic          zero = 1'b0;
   logic          mem_ready = 1'b0;
   logic          pc_write, ir_write, mem_req, mem_we, iord, pc_src, reg_write;
   logic [1:0]    alu_src_a, alu_src_b, alu_op, wb_sel;
   logic          instr_retired, trap, trap_cause;
   logic [CW-1:0] retire_count;
   logic [3:0]    state;

   typedef struct packed {
      logic [3:0]    st;
      logic          pcw, irw, req, we, iord;
      logic [1:0]    sa, sb, aop;
      logic          psrc, rw;
      logic [1:0]    wb;
      logic          ret, trap, cause;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    checks = 0;
   int    errors = 0;
   int    model_cnt = 0;

   riscv_multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we),
      .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
      .instr_retired(instr_retired), .retire_count(retire_count), .trap(trap),
      .trap_cause(trap_cause), .state(state)
   );

   always #5 clk = ~clk;

   // Expected control outputs of one phase of an instruction, taken straight
   // from the phase table. Retirement marks the phase that ends an
   // instruction; the counter value is filled in by the stimulus side.
   function automatic exp_t ph(input int s, input logic rdy, input logic z);
      exp_t e;
      e    = '0;
      e.st = 4'(s);
      case (s)
         0:  begin e.req = 1; e.sb = 1; e.pcw = rdy; e.irw = rdy; end
         1:  begin e.sa = 2; e.sb = 2; end
         2:  begin e.sa = 1; e.sb = 2; end
         3:  begin e.req = 1; e.iord = 1; end
         4:  begin e.rw = 1; e.wb = 1; e.ret = 1; end
         5:  begin e.req = 1; e.we = 1; e.iord = 1; e.ret = rdy; end
         6:  begin e.sa = 1; e.aop = 2; end
         7:  begin e.sa = 1; e.sb = 2; e.aop = 2; end
         8:  begin e.rw = 1; e.ret = 1; end
         9:  begin e.sa = 1; e.aop = 1; e.psrc = 1; e.pcw = z; e.ret = 1; end
         10: begin e.pcw = 1; e.psrc = 1; e.rw = 1; e.wb = 2; e.ret = 1; end
         default: e.trap = 1;
      endcase
      return e;
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Drive one cycle of inputs, queue what the DUT should show during it,
   // then advance to just after the next rising edge.
   task automatic applyStimulus(input logic r, input logic rdy, input logic z,
                                input logic [6:0] op, input exp_t e_in, input string tag);
      exp_t e;
      e         = e_in;
      rst       = r;
      mem_ready = rdy;
      zero      = z;
      opcode    = op;
      if (r) begin
         e         = '0;
         model_cnt = 0;
      end else begin
         e.cnt = CW'(model_cnt);
         if (e.ret) model_cnt = (model_cnt + 1) % (1 << CW);
      end
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
   endtask

   // Trap phase with its cause attached.
   function automatic exp_t trap_ph(input logic cause);
      exp_t e;
      e       = ph(11, 1'b0, 1'b0);
      e.cause = cause;
      return e;
   endfunction

   // One instruction: fw fetch stalls, mw data-memory stalls, zsel 0/1
   // forces the zero flag in BRANCH, 2 randomises it.
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input int zsel);
      logic r, z;
      for (int i = 0; i < fw; i++)
         applyStimulus(0, 0, rbit(), 7'($urandom), ph(0, 0, 0), "fetch_wait");
      applyStimulus(0, 1, rbit(), 7'($urandom), ph(0, 1, 0), "fetch");
      r = rbit();
      applyStimulus(0, r, rbit(), op, ph(1, r, 0), "decode");
      case (op)
         OP_LOAD, OP_STORE: begin
            r = rbit();
            applyStimulus(0, r, rbit(), op, ph(2, r, 0), "memadr");
            for (int i = 0; i < mw; i++)
               applyStimulus(0, 0, rbit(), op, ph(op == OP_LOAD ? 3 : 5, 0, 0), "mem_wait");
            applyStimulus(0, 1, rbit(), op, ph(op == OP_LOAD ? 3 : 5, 1, 0), "mem_done");
            if (op == OP_LOAD) begin
               r = rbit();
               applyStimulus(0, r, rbit(), op, ph(4, r, 0), "wb_mem");
            end
         end
         OP_R, OP_I: begin
            r = rbit();
            applyStimulus(0, r, rbit(), op, ph(op == OP_R ? 6 : 7, r, 0), "exec");
            r = rbit();
            applyStimulus(0, r, rbit(), op, ph(8, r, 0), "wb_alu");
         end
         OP_BRANCH: begin
            z = (zsel == 2) ? rbit() : 1'(zsel);
            r = rbit();
            applyStimulus(0, r, z, op, ph(9, r, z), "branch");
         end
         OP_JAL: begin
            r = rbit();
            applyStimulus(0, r, rbit(), op, ph(10, r, 0), "jal");
         end
         default: begin
            for (int i = 0; i < 20; i++)
               applyStimulus(0, rbit(), rbit(), op, trap_ph(0), "trap_illegal");
         end
      endcase
   endtask

   // Monitor side: compare one queued expectation with the DUT outputs.
   task automatic checkOutput();
      exp_t  a, e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = '{st: state, pcw: pc_write, irw: ir_write, req: mem_req, we: mem_we,
            iord: iord, sa: alu_src_a, sb: alu_src_b, aop: alu_op, psrc: pc_src,
            rw: reg_write, wb: wb_sel, ret: instr_retired, trap: trap,
            cause: trap_cause, cnt: retire_count};
      checks++;
      if (a !== e) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", t, $time, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) checkOutput();
   end

   initial begin
      logic [6:0] ops[6];
      ops[0] = OP_LOAD; ops[1] = OP_STORE; ops[2] = OP_R;
      ops[3] = OP_I;    ops[4] = OP_BRANCH; ops[5] = OP_JAL;

      @(posedge clk);
      #1;
      $display("[TB] reset");
      repeat (3) applyStimulus(1, 1, 0, 7'd0, '0, "reset");

      $display("[TB] directed instructions");
      run_instr(OP_R, 0, 0, 2);
      run_instr(OP_LOAD, 0, 3, 2);
      run_instr(OP_BRANCH, 0, 0, 1);
      run_instr(OP_BRANCH, 0, 0, 0);
      run_instr(OP_STORE, 1, 2, 2);
      run_instr(OP_JAL, 0, 0, 2);
      run_instr(7'b0000000, 0, 0, 2);
      applyStimulus(1, 1, 0, 7'd0, '0, "reset_after_trap");

      $display("[TB] fetch timeout");
      run_instr(OP_I, 0, 0, 2);
      for (int i = 0; i < TO; i++)
         applyStimulus(0, 0, 0, OP_R, ph(0, 0, 0), "timeout_fetch_wait");
      repeat (3) applyStimulus(0, rbit(), 0, OP_R, trap_ph(1), "trap_timeout");
      applyStimulus(1, 0, 0, 7'd0, '0, "reset_after_timeout");
      run_instr(OP_R, TO - 1, 0, 2);

      $display("[TB] store timeout");
      applyStimulus(0, 1, 0, OP_STORE, ph(0, 1, 0), "fetch");
      applyStimulus(0, 0, 0, OP_STORE, ph(1, 0, 0), "decode");
      applyStimulus(0, 0, 0, OP_STORE, ph(2, 0, 0), "memadr");
      for (int i = 0; i < TO; i++)
         applyStimulus(0, 0, 0, OP_STORE, ph(5, 0, 0), "timeout_memwr_wait");
      repeat (2) applyStimulus(0, 1, 0, OP_STORE, trap_ph(1), "trap_timeout_memwr");
      applyStimulus(1, 1, 0, 7'd0, '0, "reset_after_memwr_timeout");

      $display("[TB] reset during load wait");
      run_instr(OP_JAL, 0, 0, 2);
      applyStimulus(0, 1, 0, OP_LOAD, ph(0, 1, 0), "fetch");
      applyStimulus(0, 0, 0, OP_LOAD, ph(1, 0, 0), "decode");
      applyStimulus(0, 0, 0, OP_LOAD, ph(2, 0, 0), "memadr");
      applyStimulus(0, 0, 0, OP_LOAD, ph(3, 0, 0), "memrd_wait");
      applyStimulus(1, 0, 0, OP_LOAD, '0, "reset_mid_wait");
      run_instr(OP_R, 0, 0, 2);

      $display("[TB] random instruction stream");
      for (int n = 0; n < 40; n++)
         run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, TO - 1),
                   $urandom_range(0, TO - 1), 2);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
- Moore-style FSM that sequences a multi-cycle RV32I datapath sharing one memory port for instruction fetch and data access.
- Drives PC/IR write enables, memory request handshake, ALU operand selects and ALU op class, register write-back and next-PC selection.
- Sits beside the instruction decoder, which supplies `opcode`. It replaces the single-cycle control unit in the multi-cycle core variant.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready in any memory state. 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  7  instruction[6:0] from the IR, valid from DECODE onward
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current request this cycle
- pc_write  output  1  PC register load enable
- ir_write  output  1  IR load enable; oldPC latches with IR
- mem_req  output  1  memory request
- mem_we  output  1  write strobe, valid with mem_req
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- alu_src_a  output  2  0=PC, 1=regA, 2=oldPC
- alu_src_b  output  2  0=regB, 1=const 4, 2=immediate
- alu_op  output  2  00=add, 01=sub, 10=funct-decoded
- pc_src  output  1  0=ALU result (combinational), 1=ALUOut
- reg_write  output  1  register file write enable
- wb_sel  output  2  write-back source: 0=ALUOut, 1=MDR, 2=PC
- instr_retired  output  1  one-cycle pulse when an instruction completes
- retire_count  output  CNT_W  retired-instruction count
- trap  output  1  halted on illegal opcode or bus timeout
- trap_cause  output  1  0=illegal opcode, 1=memory timeout
- state  output  4  current state encoding, for debug

Behaviour:
- Reset:
  - While rst=1, all outputs are 0 and retire_count=0.
  - On the first cycle after rst falls, state=FETCH.
  - Reset mid-wait drops mem_req in that same rst cycle.
- Outputs are decoded from state, plus mem_ready/zero where noted. Signals not listed for a state are 0.
- FETCH (0):
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=00, pc_src=0.
  - When mem_ready=1: ir_write=1 and pc_write=1, then go to DECODE. Otherwise hold.
- DECODE (1):
  - Drives alu_src_a=2, alu_src_b=2, alu_op=00, so ALUOut gets the branch/JAL target.
  - Dispatch on opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - anything else -> TRAP with trap_cause=0
- MEMADR (2): alu_src_a=1, alu_src_b=2, alu_op=00. Go to MEMRD if opcode=0000011, else MEMWR.
- MEMRD (3): mem_req=1, iord=1. On mem_ready go to WB_MEM.
- WB_MEM (4): reg_write=1, wb_sel=1, then FETCH.
- MEMWR (5): mem_req=1, mem_we=1, iord=1. On mem_ready go to FETCH (retires).
- EXEC_R (6): alu_src_a=1, alu_src_b=0, alu_op=10, then WB_ALU.
- EXEC_I (7): alu_src_a=1, alu_src_b=2, alu_op=10, then WB_ALU.
- WB_ALU (8): reg_write=1, wb_sel=0, then FETCH.
- BRANCH (9):
  - Drives alu_src_a=1, alu_src_b=0, alu_op=01, pc_src=1, pc_write=zero. Only BEQ semantics are implemented.
  - Always goes to FETCH.
- JAL (10):
  - Drives pc_write=1, pc_src=1, reg_write=1, wb_sel=2. The register file captures PC (already oldPC+4) on the same edge the PC loads the target.
  - Then FETCH.
- TRAP (11):
  - trap=1; all other outputs 0.
  - Held until rst. trap_cause holds its value.
- Memory handshake and timeout:
  - mem_req and mem_we stay stable until the cycle with mem_ready=1. mem_ready without mem_req is ignored.
  - A wait counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle with mem_req=1 and mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT, go to TRAP with trap_cause=1.
  - mem_ready=1 in the same cycle the limit is reached takes priority (completes normally).
- Retirement:
  - instr_retired=1 in the cycle whose next state is FETCH, leaving WB_MEM, MEMWR (ready), WB_ALU, BRANCH or JAL. Never on entry to TRAP.
  - retire_count increments on that edge and wraps at 2^CNT_W.
- Cycle counts with mem_ready tied high:
  - R/I-type: 4 cycles
  - load: 5
  - store: 4
  - branch: 3
  - jal: 3
  - Each memory wait cycle adds 1.

Test Plan:
- Reset: hold rst 3 cycles with mem_ready=1 -> all outputs 0. First post-reset cycle has state=0, mem_req=1, iord=0.
- R-type: opcode=0110011, mem_ready=1 -> states 0,1,6,8. reg_write only in state 8 with wb_sel=0. instr_retired pulses once; retire_count=1.
- Load with delay: opcode=0000011, mem_ready low 3 cycles in MEMRD -> mem_req/iord held 4 cycles. Then WB_MEM with wb_sel=1. Total 8 cycles.
- Branch: opcode=1100011 with zero=1 -> pc_write=1, pc_src=1 in BRANCH. Repeat with zero=0 -> pc_write=0. Both retire.
- JAL then illegal: opcode=1101111 -> JAL has pc_write=reg_write=1, wb_sel=2. Next opcode=0000000 -> TRAP, trap=1, trap_cause=0; held 20 cycles until rst.
- Timeout: MEM_TIMEOUT=4, mem_ready=0 in FETCH -> TRAP after 4 wait cycles, trap_cause=1, retire_count unchanged. Repeat with mem_ready=1 on the 4th cycle -> normal DECODE.
